// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file write arbiter.
// Requester A (ALU writeback) and requester B (memory load) share one write port. The
// grant is combinational and goes to one requester per cycle. Grant priority alternates
// between A and B. The accepted write is registered onto the wr_* outputs one cycle later.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [2:0]        a_dest,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [2:0]        b_dest,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              hold,
  output logic              wr_en,
  output logic [2:0]        wr_dest,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        wr_sel,
  output logic [7:0]        wr_count
);

  typedef enum logic {PrioA, PrioB} prio_e;

  prio_e             prio_q, prio_d;
  logic              xfer;
  logic [2:0]        sel_dest;
  logic [DATA_W-1:0] sel_data;

  logic              wr_en_q;
  logic [2:0]        wr_dest_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [7:0]        wr_sel_q;
  logic [7:0]        wr_count_q;

  // Grant selection, write mux and next priority pointer.
  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    prio_d   = prio_q;
    sel_dest = a_dest;
    sel_data = a_data;
    // Ready stays low during reset, so a request seen in that window is dropped.
    if (!reset && !hold) begin
      a_ready = a_valid && (!b_valid || (prio_q == PrioA));
      b_ready = b_valid && (!a_valid || (prio_q == PrioB));
    end
    if (b_ready) begin
      sel_dest = b_dest;
      sel_data = b_data;
      prio_d   = PrioA;
    end else if (a_ready) begin
      prio_d   = PrioB;
    end
    xfer = a_ready || b_ready;
  end

  // Registered write port and the transfer counter. dest/data hold when no transfer occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q     <= PrioA;
      wr_en_q    <= 1'b0;
      wr_dest_q  <= 3'd0;
      wr_data_q  <= '0;
      wr_sel_q   <= 8'h00;
      wr_count_q <= 8'd0;
    end else begin
      prio_q   <= prio_d;
      wr_en_q  <= xfer;
      wr_sel_q <= xfer ? (8'h01 << sel_dest) : 8'h00;
      if (xfer) begin
        wr_dest_q  <= sel_dest;
        wr_data_q  <= sel_data;
        wr_count_q <= wr_count_q + 8'd1;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_dest  = wr_dest_q;
  assign wr_data  = wr_data_q;
  assign wr_sel   = wr_sel_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: a vector table plus hand-written sequences.
// The table holds the expected grants. A scoreboard queue holds the expected registered writes.
module tb_regfile_wr_arbiter;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid, hold;
  logic [2:0]    a_dest, b_dest;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          wr_en;
  logic [2:0]    wr_dest;
  logic [DW-1:0] wr_data;
  logic [7:0]    wr_sel;
  logic [7:0]    wr_count;

  regfile_wr_arbiter #(.DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_dest   (a_dest),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_dest   (b_dest),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .hold     (hold),
    .wr_en    (wr_en),
    .wr_dest  (wr_dest),
    .wr_data  (wr_data),
    .wr_sel   (wr_sel),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          av;
    logic [2:0]    ad;
    logic [DW-1:0] adat;
    logic          bv;
    logic [2:0]    bd;
    logic [DW-1:0] bdat;
    logic          h;
    logic          ear;
    logic          ebr;
  } vec_t;

  typedef struct {
    logic          en;
    logic [2:0]    dest;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [2:0]    m_dest;
  logic [DW-1:0] m_data;
  logic [7:0]    m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check the grant, then check the registered write after posedge.
  task automatic step(input string name, input vec_t v);
    wr_t exp_w;
    wr_t got;
    @(negedge clk);
    a_valid = v.av; a_dest = v.ad; a_data = v.adat;
    b_valid = v.bv; b_dest = v.bd; b_data = v.bdat;
    hold    = v.h;
    #1;
    check({name, "_a_ready"}, 32'(a_ready), 32'(v.ear));
    check({name, "_b_ready"}, 32'(b_ready), 32'(v.ebr));
    exp_w.en   = v.ear | v.ebr;
    exp_w.dest = v.ebr ? v.bd : v.ad;
    exp_w.data = v.ebr ? v.bdat : v.adat;
    sb_q.push_back(exp_w);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      if (got.en) begin
        m_dest  = got.dest;
        m_data  = got.data;
        m_count = m_count + 8'd1;
      end
      check({name, "_wr_en"}, 32'(wr_en), 32'(got.en));
      check({name, "_wr_sel"}, 32'(wr_sel), got.en ? 32'(8'h01 << got.dest) : 32'h0);
      check({name, "_wr_dest"}, 32'(wr_dest), 32'(m_dest));
      check({name, "_wr_data"}, 32'(wr_data), 32'(m_data));
      check({name, "_wr_count"}, 32'(wr_count), 32'(m_count));
    end
  endtask

  // Builds a vector record; keeps the stimulus lines below short.
  function automatic vec_t mk(input logic av, input logic [2:0] ad, input logic [DW-1:0] adat,
                              input logic bv, input logic [2:0] bd, input logic [DW-1:0] bdat,
                              input logic h, input logic ear, input logic ebr);
    vec_t v;
    v.av = av; v.ad = ad; v.adat = adat;
    v.bv = bv; v.bd = bd; v.bdat = bdat;
    v.h = h; v.ear = ear; v.ebr = ebr;
    return v;
  endfunction

  task automatic do_reset(input string name);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check({name, "_rst_a_ready"}, 32'(a_ready), 32'd0);
    check({name, "_rst_b_ready"}, 32'(b_ready), 32'd0);
    check({name, "_rst_wr_en"}, 32'(wr_en), 32'd0);
    check({name, "_rst_wr_sel"}, 32'(wr_sel), 32'd0);
    check({name, "_rst_wr_dest"}, 32'(wr_dest), 32'd0);
    check({name, "_rst_wr_data"}, 32'(wr_data), 32'd0);
    check({name, "_rst_wr_count"}, 32'(wr_count), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b0;
    m_dest = 3'd0; m_data = '0; m_count = 8'd0;
    sb_q.delete();
  endtask

  vec_t tbl[11];

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0;
    a_dest = 3'd0; b_dest = 3'd0; a_data = '0; b_data = '0;

    // Grants expected from the reset pointer (A); the pointer flips to the loser after each transfer.
    tbl[0]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0);  // idle
    tbl[1]  = mk(1, 3'd5, 16'h1234, 0, 3'd0, 16'h0000, 0, 1, 0);  // A only -> sel 8'h20
    tbl[2]  = mk(0, 3'd0, 16'h0000, 1, 3'd3, 16'h5555, 0, 0, 1);  // B only
    tbl[3]  = mk(1, 3'd7, 16'h0001, 1, 3'd0, 16'h0002, 0, 1, 0);  // both, ptr A
    tbl[4]  = mk(1, 3'd7, 16'h0001, 1, 3'd0, 16'h0002, 0, 0, 1);  // both, ptr B, reg 0
    tbl[5]  = mk(1, 3'd1, 16'hCAFE, 1, 3'd6, 16'hBEEF, 1, 0, 0);  // hold
    tbl[6]  = mk(0, 3'd1, 16'hCAFE, 0, 3'd6, 16'hBEEF, 1, 0, 0);  // hold, idle
    tbl[7]  = mk(1, 3'd1, 16'hCAFE, 1, 3'd6, 16'hBEEF, 0, 1, 0);  // ptr still A after hold
    tbl[8]  = mk(1, 3'd4, 16'h0044, 0, 3'd0, 16'h0000, 0, 1, 0);  // A alone despite ptr B
    tbl[9]  = mk(1, 3'd0, 16'h0F0F, 1, 3'd2, 16'hF0F0, 0, 0, 1);  // ptr stayed B
    tbl[10] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0);  // idle, dest/data hold

    do_reset("init");
    for (int i = 0; i < 11; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Contention right after reset on the same destination: A first, then B, B's data last.
    do_reset("cont");
    step("cont0", mk(1, 3'd2, 16'hAAAA, 1, 3'd2, 16'hBBBB, 0, 1, 0));
    step("cont1", mk(0, 3'd2, 16'hAAAA, 1, 3'd2, 16'hBBBB, 0, 0, 1));
    step("cont2", mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0));
    check("cont_final_data", 32'(wr_data), 32'hBBBB);

    // Fairness: six cycles of contention alternate A,B with no bubbles.
    do_reset("fair");
    for (int i = 0; i < 6; i++)
      step($sformatf("fair%0d", i),
           mk(1, 3'(i), 16'(16'hA000 + i), 1, 3'(7 - i), 16'(16'hB000 + i), 0,
              (i % 2) == 0, (i % 2) == 1));
    check("fair_count", 32'(wr_count), 32'd6);

    // Hold for three cycles, then release: pointer is back on A.
    for (int i = 0; i < 3; i++)
      step($sformatf("hold%0d", i), mk(1, 3'd3, 16'h3333, 1, 3'd4, 16'h4444, 1, 0, 0));
    step("hold_rel", mk(1, 3'd3, 16'h3333, 1, 3'd4, 16'h4444, 0, 1, 0));
    step("hold_rel2", mk(0, 3'd3, 16'h3333, 1, 3'd4, 16'h4444, 0, 0, 1));

    // Counter wrap: 256 writes bring it to 0, the 257th gives 1.
    do_reset("wrap");
    for (int i = 0; i < 257; i++)
      step($sformatf("wrap%0d", i), mk(1, 3'(i), 16'(i), 0, 3'd0, 16'h0000, 0, 1, 0));
    check("wrap_final_count", 32'(wr_count), 32'd1);

    // Asynchronous reset between edges while a write is on the port.
    do_reset("async");
    step("async_pre", mk(1, 3'd6, 16'hABCD, 0, 3'd0, 16'h0000, 0, 1, 0));
    #2;
    reset = 1'b1;
    #1;
    check("async_wr_en", 32'(wr_en), 32'd0);
    check("async_wr_sel", 32'(wr_sel), 32'd0);
    check("async_wr_dest", 32'(wr_dest), 32'd0);
    check("async_wr_data", 32'(wr_data), 32'd0);
    check("async_wr_count", 32'(wr_count), 32'd0);
    check("async_a_ready", 32'(a_ready), 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    reset = 1'b0;
    m_dest = 3'd0; m_data = '0; m_count = 8'd0;
    step("async_post", mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
